urv_dm_arbiter: RTL and testbench

URV_DM_ARBITER -- requirements
Module: urv_dm_arbiter

---
 rtl/urv_dm_arbiter.sv | 140 ++++++++++++++
 tb/tb_urv_dm_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_dm_arbiter.sv
// Two-port data-memory arbiter: forwards one requester at a time onto a single memory port.
// Build option: define URV_DM_ARB_RR_EN for round-robin tie-breaking (default is fixed priority to port0).
module urv_dm_arbiter (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_data_s_i,
  input  logic [3:0]  p0_select_i,
  input  logic        p0_load_i,
  input  logic        p0_store_i,
  output logic        p0_ready_o,

  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_data_s_i,
  input  logic [3:0]  p1_select_i,
  input  logic        p1_load_i,
  input  logic        p1_store_i,
  output logic        p1_ready_o,

  output logic [31:0] p_data_l_o,

  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_s_o,
  output logic [3:0]  m_select_o,
  output logic        m_load_o,
  output logic        m_store_o,
  input  logic        m_ready_i,
  input  logic [31:0] m_data_l_i,

  output logic [1:0]  grant_o
);

  // state | meaning
  // IDLE  | no locked owner; a pending request is granted combinationally this cycle
  // OWN0  | port0 holds the bus until memory completes
  // OWN1  | port1 holds the bus until memory completes
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       req0, req1;
  logic       win1;
  logic [1:0] grant;

`ifdef URV_DM_ARB_RR_EN
  logic       ptr_q, ptr_d;
`endif

  assign req0 = p0_load_i | p0_store_i;
  assign req1 = p1_load_i | p1_store_i;

  // Winner when idle: port1 wins only if port0 is silent, or on a tie when the pointer favours it.
`ifdef URV_DM_ARB_RR_EN
  assign win1 = req1 & (~req0 | ptr_q);
`else
  assign win1 = req1 & ~req0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
`ifdef URV_DM_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef URV_DM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant[0] && !m_ready_i)      state_d = OWN0;
        else if (grant[1] && !m_ready_i) state_d = OWN1;
      end
      // A dropped request releases the bus as well as a completion does.
      OWN0: if (m_ready_i || !req0) state_d = IDLE;
      OWN1: if (m_ready_i || !req1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef URV_DM_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (p0_ready_o)      ptr_d = 1'b1;
    else if (p1_ready_o) ptr_d = 1'b0;
  end
`endif

  // Outputs are gated by the reset pin so nothing leaks out while reset is held.
  always_comb begin
    grant = 2'b00;
    if (rst_n_i) begin
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) grant = win1 ? 2'b10 : 2'b01;
        end
        OWN0:    grant = 2'b01;
        OWN1:    grant = 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    m_addr_o   = 32'h0;
    m_data_s_o = 32'h0;
    m_select_o = 4'h0;
    m_load_o   = 1'b0;
    m_store_o  = 1'b0;
    if (grant[0]) begin
      m_addr_o   = p0_addr_i;
      m_data_s_o = p0_data_s_i;
      m_select_o = p0_select_i;
      m_load_o   = p0_load_i;
      m_store_o  = p0_store_i;
    end else if (grant[1]) begin
      m_addr_o   = p1_addr_i;
      m_data_s_o = p1_data_s_i;
      m_select_o = p1_select_i;
      m_load_o   = p1_load_i;
      m_store_o  = p1_store_i;
    end
  end

  assign p0_ready_o = grant[0] & req0 & m_ready_i;
  assign p1_ready_o = grant[1] & req1 & m_ready_i;
  assign p_data_l_o = m_data_l_i;
  assign grant_o    = grant;

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Bench for urv_dm_arbiter: directed scenarios with literal expectations plus randomized
// traffic compared each cycle against an owner-index model of the arbitration rules.
module tb_urv_dm_arbiter;

`ifdef URV_DM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] p0_addr_i, p0_data_s_i, p1_addr_i, p1_data_s_i;
  logic [3:0]  p0_select_i, p1_select_i;
  logic        p0_load_i, p0_store_i, p1_load_i, p1_store_i;
  logic        p0_ready_o, p1_ready_o;
  logic [31:0] p_data_l_o, m_addr_o, m_data_s_o, m_data_l_i;
  logic [3:0]  m_select_o;
  logic        m_load_o, m_store_o, m_ready_i;
  logic [1:0]  grant_o;

  urv_dm_arbiter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .p0_addr_i(p0_addr_i), .p0_data_s_i(p0_data_s_i), .p0_select_i(p0_select_i),
    .p0_load_i(p0_load_i), .p0_store_i(p0_store_i), .p0_ready_o(p0_ready_o),
    .p1_addr_i(p1_addr_i), .p1_data_s_i(p1_data_s_i), .p1_select_i(p1_select_i),
    .p1_load_i(p1_load_i), .p1_store_i(p1_store_i), .p1_ready_o(p1_ready_o),
    .p_data_l_o(p_data_l_o),
    .m_addr_o(m_addr_o), .m_data_s_o(m_data_s_o), .m_select_o(m_select_o),
    .m_load_o(m_load_o), .m_store_o(m_store_o), .m_ready_i(m_ready_i),
    .m_data_l_i(m_data_l_i), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  // Model: current owner index (-1 = nobody locked) and round-robin favourite.
  int own_m = -1, own_n = -1;
  bit ptr_m = 1'b0, ptr_n = 1'b0;
  bit exp_rdy0, exp_rdy1;

  // Randomized requesters.
  bit          pend[2];
  bit          isld[2];
  logic [31:0] ad[2], dt[2];
  logic [3:0]  sl[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_neg();
    int          w;
    logic        r0, r1, rw;
    logic [1:0]  eg;
    logic [31:0] ea, ed;
    logic [3:0]  es;
    logic        el, est;
    @(negedge clk_i);
    r0 = p0_load_i | p0_store_i;
    r1 = p1_load_i | p1_store_i;
    w = -1;
    if (rst_n_i) begin
      if (own_m >= 0)     w = own_m;
      else if (r0 && r1)  w = RR ? int'(ptr_m) : 0;
      else if (r0)        w = 0;
      else if (r1)        w = 1;
    end
    eg = 2'b00; ea = '0; ed = '0; es = '0; el = 1'b0; est = 1'b0; rw = 1'b0;
    if (w == 0) begin
      eg = 2'b01; ea = p0_addr_i; ed = p0_data_s_i; es = p0_select_i;
      el = p0_load_i; est = p0_store_i; rw = r0;
    end else if (w == 1) begin
      eg = 2'b10; ea = p1_addr_i; ed = p1_data_s_i; es = p1_select_i;
      el = p1_load_i; est = p1_store_i; rw = r1;
    end
    exp_rdy0 = (w == 0) && rw && m_ready_i;
    exp_rdy1 = (w == 1) && rw && m_ready_i;
    chk("grant",    grant_o,    eg);
    chk("m_addr",   m_addr_o,   ea);
    chk("m_data_s", m_data_s_o, ed);
    chk("m_select", m_select_o, es);
    chk("m_load",   m_load_o,   el);
    chk("m_store",  m_store_o,  est);
    chk("p0_ready", p0_ready_o, exp_rdy0);
    chk("p1_ready", p1_ready_o, exp_rdy1);
    chk("p_data_l", p_data_l_o, m_data_l_i);
    own_n = own_m;
    ptr_n = ptr_m;
    if (!rst_n_i) begin
      own_n = -1; ptr_n = 1'b0;
    end else if (w < 0) begin
      own_n = -1;
    end else if (rw && m_ready_i) begin
      own_n = -1; ptr_n = (w == 0);
    end else if (!rw) begin
      own_n = -1;
    end else begin
      own_n = w;
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    own_m = own_n;
    ptr_m = ptr_n;
    #1;
  endtask

  task automatic clear_req();
    p0_load_i = 0; p0_store_i = 0; p1_load_i = 0; p1_store_i = 0;
  endtask

  task automatic drive_rand();
    for (int n = 0; n < 2; n++) begin
      if (!pend[n] && $urandom_range(0, 2) == 0) begin
        pend[n] = 1'b1;
        isld[n] = $urandom_range(0, 1) == 1;
        ad[n]   = $urandom;
        dt[n]   = $urandom;
        sl[n]   = 4'($urandom_range(1, 15));
      end
    end
    p0_load_i  = pend[0] & isld[0];  p0_store_i = pend[0] & !isld[0];
    p1_load_i  = pend[1] & isld[1];  p1_store_i = pend[1] & !isld[1];
    p0_addr_i  = pend[0] ? ad[0] : $urandom;  p0_data_s_i = dt[0];  p0_select_i = sl[0];
    p1_addr_i  = pend[1] ? ad[1] : $urandom;  p1_data_s_i = dt[1];  p1_select_i = sl[1];
    m_ready_i  = $urandom_range(0, 9) < 6;
    m_data_l_i = $urandom;
    rst_n_i    = ($urandom_range(0, 299) != 0);
  endtask

  initial begin
    rst_n_i = 0;
    p0_addr_i = 0; p0_data_s_i = 0; p0_select_i = 0;
    p1_addr_i = 0; p1_data_s_i = 0; p1_select_i = 0;
    clear_req();
    m_ready_i = 0; m_data_l_i = 32'h1234_5678;
    #1;

    // Reset holds everything quiet even with a request present.
    p0_load_i = 1; m_ready_i = 1;
    check_neg();
    chk("pin_rst_grant", grant_o, 2'b00);
    chk("pin_rst_mload", m_load_o, 1'b0);
    chk("pin_rst_rdy0", p0_ready_o, 1'b0);
    adv();
    rst_n_i = 1; clear_req(); m_ready_i = 0;
    check_neg(); adv();

    // Single zero-wait load.
    p0_load_i = 1; p0_addr_i = 32'h100; p0_select_i = 4'hF; m_ready_i = 1; m_data_l_i = 32'hDEAD_BEEF;
    check_neg();
    chk("pin_ld_mload", m_load_o, 1'b1);
    chk("pin_ld_addr", m_addr_o, 32'h100);
    chk("pin_ld_rdy0", p0_ready_o, 1'b1);
    chk("pin_ld_data", p_data_l_o, 32'hDEAD_BEEF);
    adv();
    clear_req(); m_ready_i = 0;
    check_neg(); adv();

    // Store from port1 with three wait states; port0 arrives late and is ignored.
    p1_store_i = 1; p1_addr_i = 32'h200; p1_data_s_i = 32'h55AA_00FF; p1_select_i = 4'h3;
    for (int i = 0; i < 4; i++) begin
      m_ready_i = (i == 3);
      p0_load_i = (i > 0);
      check_neg();
      chk("pin_ws_grant", grant_o, 2'b10);
      chk("pin_ws_rdy1", p1_ready_o, (i == 3));
      chk("pin_ws_rdy0", p0_ready_o, 1'b0);
      adv();
    end
    p1_store_i = 0;
    check_neg();
    chk("pin_ws_next", grant_o, 2'b01);
    adv();
    clear_req(); m_ready_i = 0;

    // Continuous tie after reset, zero-wait memory.
    rst_n_i = 0; check_neg(); adv();
    rst_n_i = 1;
    p0_load_i = 1; p1_load_i = 1; m_ready_i = 1;
    for (int i = 0; i < 6; i++) begin
      check_neg();
      chk("pin_tie_grant", grant_o, (RR && (i % 2 == 1)) ? 2'b10 : 2'b01);
      chk("pin_tie_rdy1", p1_ready_o, (RR && (i % 2 == 1)));
      adv();
    end
    clear_req(); m_ready_i = 0;
    check_neg(); adv();

    // Reset in the middle of a port0 transfer.
    p0_load_i = 1; p0_addr_i = 32'h300;
    check_neg(); adv();
    check_neg();
    chk("pin_own0_grant", grant_o, 2'b01);
    adv();
    rst_n_i = 0; m_ready_i = 1;
    check_neg();
    chk("pin_mid_grant", grant_o, 2'b00);
    chk("pin_mid_mload", m_load_o, 1'b0);
    chk("pin_mid_rdy0", p0_ready_o, 1'b0);
    adv();
    rst_n_i = 1;
    check_neg();
    chk("pin_after_rdy0", p0_ready_o, 1'b1);
    adv();
    clear_req(); m_ready_i = 0;

    // Owner abandons its request while locked.
    p1_load_i = 1; p1_addr_i = 32'h400;
    check_neg(); adv();
    p1_load_i = 0; p0_store_i = 1;
    check_neg();
    chk("pin_drop_mload", m_load_o, 1'b0);
    chk("pin_drop_mstore", m_store_o, 1'b0);
    adv();
    check_neg();
    chk("pin_drop_regrant", grant_o, 2'b01);
    adv();
    clear_req();
    check_neg(); adv();

    // Randomized traffic.
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      drive_rand();
      check_neg();
      if (exp_rdy0) pend[0] = 1'b0;
      if (exp_rdy1) pend[1] = 1'b0;
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
